// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg -- shared constants for the seven-segment scanner.
//   DIGITS_DEFAULT : default number of scanned hex digits
//   SEG_BLANK      : all segments off (active-low)
//   SEG_TABLE      : hex 0-F to active-low segments {g,f,e,d,c,b,a}
package seven_seg_pkg;

    localparam int DIGITS_DEFAULT = 5;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg -- combinational hex digit to active-low seven-segment decode.
//   hex : 4-bit digit value
//   seg : segments {g,f,e,d,c,b,a}, active-low
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner -- time-multiplexed driver for a DIGITS-digit hex display.
// A prescaler produces one scan tick every 2^DIV_WIDTH cycles; each tick
// lights the next digit. Inputs are snapshotted once per frame so a frame
// never mixes two input values.
//   clk       : clock, rising edge
//   rstN      : asynchronous active-low reset
//   dataIn    : DIGITS hex digits, digit k on [4k+3:4k]
//   dpIn      : decimal point request per digit, active-high
//   an        : anode enables, active-low, one-hot-low
//   seg       : segments {g,f,e,d,c,b,a}, active-low
//   dp        : decimal point, active-low
//   frameTick : one-cycle pulse following each frame snapshot
// Optional: define SEVEN_SEG_LZ_BLANK_EN to blank leading-zero digits
// (digit 0 is always shown). Scan timing is identical either way.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int DIV_WIDTH = 16,
    parameter int DIGITS    = DIGITS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic [4*DIGITS-1:0]   dataIn,
    input  logic [DIGITS-1:0]     dpIn,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frameTick
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIV_WIDTH-1:0]  presc;
    logic [IDX_W-1:0]      idx;
    logic [4*DIGITS-1:0]   data_snap;
    logic [DIGITS-1:0]     dp_snap;
    logic                  tick;
    logic                  last;
    logic [3:0]            cur_digit;
    logic [6:0]            dec_seg;
    logic                  blank;

    assign tick      = &presc;
    assign last      = (idx == IDX_W'(DIGITS - 1));
    assign cur_digit = data_snap[4*idx +: 4];

    hex_to_seg u_dec (
        .hex (cur_digit),
        .seg (dec_seg)
    );

`ifdef SEVEN_SEG_LZ_BLANK_EN
    // lz_mask[k] is set when digit k and every digit above it are zero.
    // Bit 0 stays clear so a value of zero still shows a single "0".
    logic [DIGITS-1:0] lz_mask;
    logic              zero_above;

    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above & (data_snap[4*k +: 4] == 4'd0);
            lz_mask[k] = zero_above;
        end
    end

    assign blank = lz_mask[idx];
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            presc     <= '0;
            idx       <= '0;
            data_snap <= '0;
            dp_snap   <= '0;
            an        <= '1;
            seg       <= SEG_BLANK;
            dp        <= 1'b1;
            frameTick <= 1'b0;
        end else begin
            presc     <= presc + 1'b1;
            frameTick <= tick && last;
            if (tick) begin
                if (blank) begin
                    an  <= '1;
                    seg <= SEG_BLANK;
                    dp  <= 1'b1;
                end else begin
                    an  <= ~(DIGITS'(1) << idx);
                    seg <= dec_seg;
                    dp  <= ~dp_snap[idx];
                end
                // The last digit of a frame still shows the old snapshot
                // (non-blocking read); the new one starts with digit 0.
                if (last) begin
                    idx       <= '0;
                    data_snap <= dataIn;
                    dp_snap   <= dpIn;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule
